serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if -- operand/result bundle for serial_subtractor.
//   start, a, b                  : request and operands (master -> slave)
//   busy, done, diff, bout,
//   d_ser, v_ser                 : status, result and serial bit stream (slave -> master)
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             d_ser;
  logic             v_ser;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, d_ser, v_ser
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, d_ser, v_ser
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor -- bit-serial unsigned subtractor, LSB first, one bit per clock.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   bus   : serial_subtractor_if.slave
//           start/a/b in; busy, done (one-cycle pulse), diff = (a-b) mod 2^WIDTH,
//           bout (a<b), d_ser/v_ser serial difference bit and its qualifier out.
// All outputs are registered. A start accepted at edge 0 gives busy in
// cycles 1..WIDTH and done in cycle WIDTH+1.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dser_q, dser_d;

  logic d_cur;
  logic br_nxt;
  logic last_bit;
  logic accept;

  always_comb begin
    d_cur    = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
    accept   = bus.start && ((state_q == IDLE) || (state_q == DONE));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    dser_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          diff_d  = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          bout_d  = 1'b0;
          // Bit 0 is registered at the accept edge so d_ser is valid in the
          // first busy cycle.
          dser_d  = bus.a[0] ^ bus.b[0];
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        diff_d = {d_cur, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = br_nxt;
        if (last_bit) begin
          state_d = DONE;
          bout_d  = br_nxt;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          // Look ahead one bit so the registered d_ser matches the bit being
          // folded into diff during the following cycle.
          dser_d = a_q[1] ^ b_q[1] ^ br_nxt;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dser_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dser_q  <= dser_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.v_ser = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.d_ser = dser_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor -- directed and random checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives start with av/bv in the current cycle and follows the operation
  // to its DONE cycle, where it returns without advancing the clock.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit full, input bit mid_start);
    logic [W:0]   t;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    t        = {1'b0, av} - {1'b0, bv};
    exp_diff = t[W-1:0];
    exp_bout = (av < bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    if (full) begin
      check("diff_cleared_at_start", 32'(bus.diff), 32'h0);
      check("bout_cleared_at_start", 32'(bus.bout), 32'h0);
    end
    for (int i = 0; i < int'(W); i++) begin
      if (full) begin
        check("busy_run",  32'(bus.busy),  32'h1);
        check("v_ser_run", 32'(bus.v_ser), 32'h1);
        check("done_run",  32'(bus.done),  32'h0);
        check("d_ser_bit", 32'(bus.d_ser), 32'(exp_diff[i]));
      end
      if (mid_start && i == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'h77;
        bus.b     = 8'h99;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check("done_pulse", 32'(bus.done), 32'h1);
    check("diff",       32'(bus.diff), 32'(exp_diff));
    check("bout",       32'(bus.bout), 32'(exp_bout));
    if (full) begin
      check("busy_in_done",  32'(bus.busy),  32'h0);
      check("v_ser_in_done", 32'(bus.v_ser), 32'h0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(bus.busy),  32'h0);
    check({tag, "_done"},  32'(bus.done),  32'h0);
    check({tag, "_diff"},  32'(bus.diff),  32'h0);
    check({tag, "_bout"},  32'(bus.bout),  32'h0);
    check({tag, "_d_ser"}, 32'(bus.d_ser), 32'h0);
    check({tag, "_v_ser"}, 32'(bus.v_ser), 32'h0);
  endtask

  logic [W-1:0] dir_a [4] = '{8'h03, 8'h00, 8'hFF, 8'h00};
  logic [W-1:0] dir_b [4] = '{8'h05, 8'h00, 8'h01, 8'hFF};

  initial begin
    int saw_done;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // 5 - 3 with full cycle-by-cycle checks, then the held result.
    do_op(8'h05, 8'h03, 1'b1, 1'b0);
    tick();
    check("done_single_cycle", 32'(bus.done), 32'h0);
    check("diff_held",         32'(bus.diff), 32'h02);
    check("bout_held",         32'(bus.bout), 32'h0);
    tick();

    foreach (dir_a[k]) begin
      do_op(dir_a[k], dir_b[k], 1'b1, 1'b0);
      tick();
    end

    // start during RUN with new operands must be ignored.
    do_op(8'h5A, 8'h3C, 1'b1, 1'b1);
    tick();
    check("mid_start_no_second_busy", 32'(bus.busy), 32'h0);
    check("mid_start_no_second_done", 32'(bus.done), 32'h0);
    tick();

    // Back-to-back: start asserted in the DONE cycle.
    do_op(8'h05, 8'h03, 1'b1, 1'b0);
    do_op(8'h10, 8'h01, 1'b1, 1'b0);
    tick();

    // Reset in cycle 5 of RUN discards the operation.
    bus.a     = 8'hA5;
    bus.b     = 8'h3C;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    check("busy_before_rst", 32'(bus.busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_run_reset");
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) saw_done++;
      tick();
    end
    check("no_activity_after_rst", 32'(saw_done), 32'h0);
    do_op(8'h81, 8'h80, 1'b1, 1'b0);
    tick();

    // Reset wins over start in the same cycle.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h44;
    bus.b     = 8'h11;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    check_all_zero("rst_over_start");
    tick();
    check("rst_over_start_stays_idle", 32'(bus.busy), 32'h0);

    // Random operands, randomly back-to-back or with an idle gap.
    for (int n = 0; n < 1000; n++) begin
      do_op(W'($urandom), W'($urandom), 1'b0, 1'b0);
      if ($urandom_range(1, 0) == 1) tick();
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
